// File: rtl/pot_cook_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pot_cook_scheduler_if                                  |
// | Description : Grid-update handshake between the pot cook scheduler   |
// |               (master) and the action block (slave).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface pot_cook_scheduler_if;
  logic       upd_valid;
  logic [1:0] upd_idx;
  logic [3:0] upd_code;
  logic       upd_ready;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_code,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_code,
    output upd_ready
  );
endinterface
`default_nettype wire

// File: rtl/pot_cook_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pot_cook_scheduler                                     |
// | Description : Per-pot cooking timers (raw -> cooked -> fire) with a  |
// |               round-robin arbiter onto the single grid-update port.  |
// |               Optional macro POT_BURN_EN builds the burn/fire phase; |
// |               without it a cooked pot stays cooked forever.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pot_cook_scheduler #(
  parameter int NUM_POTS       = 4,
  parameter int COOK_TIME      = 10,
  parameter int BURN_TIME      = 5,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic                     vsync,
  input  logic                     reset,
  input  logic [2:0]               game_state,
  input  logic [NUM_POTS-1:0][3:0] pot_cell,
  pot_cook_scheduler_if.master     upd,
  output logic [NUM_POTS-1:0][3:0] pot_time,
  output logic                     fire_alarm
);

  localparam logic [2:0] GS_PLAY      = 3'd2;
  localparam logic [3:0] G_POT_RAW    = 4'd6;
  localparam logic [3:0] G_POT_COOKED = 4'd7;
  localparam logic [3:0] COOK_T       = 4'(COOK_TIME);

  localparam int                PS_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(FRAMES_PER_SEC - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COOKING   = 3'd1;
  localparam logic [2:0] S_COOK_PEND = 3'd2;
  localparam logic [2:0] S_COOKED    = 3'd3;
`ifdef POT_BURN_EN
  localparam logic [2:0] S_FIRE_PEND = 3'd4;
  localparam logic [2:0] S_ON_FIRE   = 3'd5;
  localparam logic [3:0] G_POT_FIRE  = 4'd8;
  localparam logic [3:0] BURN_T      = 4'(BURN_TIME);
`endif

  // Parameter sanity: timers are 4 bits and the pot index is 2 bits wide.
  if (COOK_TIME < 1 || COOK_TIME > 15) begin : g_bad_cook_time
    $error("pot_cook_scheduler: COOK_TIME must be 1..15");
  end
  if (BURN_TIME < 1 || BURN_TIME > 15) begin : g_bad_burn_time
    $error("pot_cook_scheduler: BURN_TIME must be 1..15");
  end
  if (NUM_POTS < 1 || NUM_POTS > 4) begin : g_bad_num_pots
    $error("pot_cook_scheduler: NUM_POTS must be 1..4");
  end
  if (FRAMES_PER_SEC < 1) begin : g_bad_fps
    $error("pot_cook_scheduler: FRAMES_PER_SEC must be at least 1");
  end

  logic [PS_W-1:0]              presc_q, presc_d;
  logic                         tick;
  logic [NUM_POTS-1:0][2:0]     state_q, state_d;
  logic [NUM_POTS-1:0][3:0]     time_q, time_d;
  logic [NUM_POTS-1:0]          presented;
  logic [NUM_POTS-1:0]          pend_stay;
  logic                         accept;
  logic                         upd_valid_q, upd_valid_d;
  logic [1:0]                   upd_idx_q, upd_idx_d;
  logic [3:0]                   upd_code_q, upd_code_d;
  logic [1:0]                   rr_ptr_q, rr_ptr_d;
  logic [1:0]                   cand;
  logic                         found;
  logic                         fire_alarm_q, fire_alarm_d;

  assign accept = upd_valid_q & upd.upd_ready;

  // One-second tick generator; frozen outside PLAY.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (game_state == GS_PLAY) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Per-pot phase FSM and countdown; removal takes priority over a tick.
  always_comb begin
    for (int i = 0; i < NUM_POTS; i++) begin
      presented[i] = upd_valid_q && (upd_idx_q == 2'(i));
      state_d[i]   = state_q[i];
      time_d[i]    = time_q[i];
      pend_stay[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (pot_cell[i] == G_POT_RAW) begin
            state_d[i] = S_COOKING;
            time_d[i]  = COOK_T;
          end
        end
        S_COOKING: begin
          if (pot_cell[i] != G_POT_RAW) begin
            state_d[i] = S_IDLE;
            time_d[i]  = '0;
          end else if (tick) begin
            if (time_q[i] > 4'd1) begin
              time_d[i] = time_q[i] - 4'd1;
            end else begin
              time_d[i]  = '0;
              state_d[i] = S_COOK_PEND;
            end
          end
        end
        S_COOK_PEND: begin
          // A presented request must run to acceptance even if the pot left.
          if (accept && presented[i]) begin
            state_d[i] = S_COOKED;
`ifdef POT_BURN_EN
            time_d[i]  = BURN_T;
`else
            time_d[i]  = '0;
`endif
          end else if (!presented[i] && pot_cell[i] != G_POT_RAW) begin
            state_d[i] = S_IDLE;
            time_d[i]  = '0;
          end
        end
        S_COOKED: begin
          // RAW is tolerated because the COOKED write lands a frame later.
          if (pot_cell[i] != G_POT_COOKED && pot_cell[i] != G_POT_RAW) begin
            state_d[i] = S_IDLE;
            time_d[i]  = '0;
          end
`ifdef POT_BURN_EN
          else if (tick) begin
            if (time_q[i] > 4'd1) begin
              time_d[i] = time_q[i] - 4'd1;
            end else begin
              time_d[i]  = '0;
              state_d[i] = S_FIRE_PEND;
            end
          end
`endif
        end
`ifdef POT_BURN_EN
        S_FIRE_PEND: begin
          if (accept && presented[i]) begin
            state_d[i] = S_ON_FIRE;
            time_d[i]  = '0;
          end else if (!presented[i] && pot_cell[i] != G_POT_COOKED &&
                       pot_cell[i] != G_POT_RAW) begin
            state_d[i] = S_IDLE;
            time_d[i]  = '0;
          end
        end
        S_ON_FIRE: begin
          if (pot_cell[i] != G_POT_FIRE && pot_cell[i] != G_POT_COOKED) begin
            state_d[i] = S_IDLE;
            time_d[i]  = '0;
          end
        end
`endif
        default: begin
          state_d[i] = S_IDLE;
          time_d[i]  = '0;
        end
      endcase
      // Only pots that are pending now and stay pending are eligible.
`ifdef POT_BURN_EN
      pend_stay[i] = (state_q[i] == S_COOK_PEND || state_q[i] == S_FIRE_PEND) &&
                     (state_d[i] == state_q[i]);
`else
      pend_stay[i] = (state_q[i] == S_COOK_PEND) && (state_d[i] == state_q[i]);
`endif
    end
  end

  // Round-robin request selection; a stalled request holds its fields.
  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_idx_d   = upd_idx_q;
    upd_code_d  = upd_code_q;
    rr_ptr_d    = rr_ptr_q;
    cand        = '0;
    found       = 1'b0;
    if (accept) begin
      rr_ptr_d = (upd_idx_q == 2'(NUM_POTS - 1)) ? 2'd0 : upd_idx_q + 2'd1;
    end
    if (!upd_valid_q || accept) begin
      upd_valid_d = 1'b0;
      for (int k = 0; k < NUM_POTS; k++) begin
        cand = 2'((int'(rr_ptr_d) + k) % NUM_POTS);
        if (!found && pend_stay[cand]) begin
          found       = 1'b1;
          upd_valid_d = 1'b1;
          upd_idx_d   = cand;
`ifdef POT_BURN_EN
          upd_code_d  = (state_q[cand] == S_FIRE_PEND) ? G_POT_FIRE : G_POT_COOKED;
`else
          upd_code_d  = G_POT_COOKED;
`endif
        end
      end
    end
  end

  // Alarm follows the ON_FIRE states being entered on this edge.
  always_comb begin
    fire_alarm_d = 1'b0;
`ifdef POT_BURN_EN
    for (int i = 0; i < NUM_POTS; i++) begin
      if (state_d[i] == S_ON_FIRE) begin
        fire_alarm_d = 1'b1;
      end
    end
`endif
  end

  // State registers, updated on the falling vsync edge.
  always_ff @(negedge vsync or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      state_q      <= '0;
      time_q       <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_code_q   <= '0;
      rr_ptr_q     <= '0;
      fire_alarm_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      state_q      <= state_d;
      time_q       <= time_d;
      upd_valid_q  <= upd_valid_d;
      upd_idx_q    <= upd_idx_d;
      upd_code_q   <= upd_code_d;
      rr_ptr_q     <= rr_ptr_d;
      fire_alarm_q <= fire_alarm_d;
    end
  end

  assign upd.upd_valid = upd_valid_q;
  assign upd.upd_idx   = upd_idx_q;
  assign upd.upd_code  = upd_code_q;
  assign pot_time      = time_q;
  assign fire_alarm    = fire_alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_pot_cook_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pot_cook_scheduler                                  |
// | Description : Directed self-checking bench for pot_cook_scheduler.   |
// |               Expectations for the burn phase follow POT_BURN_EN.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pot_cook_scheduler;
  localparam int NP = 4;
`ifdef POT_BURN_EN
  localparam logic [3:0] EXP_BURN = 4'd5;
`else
  localparam logic [3:0] EXP_BURN = 4'd0;
`endif

  logic               vsync = 1'b0;
  logic               reset = 1'b1;
  logic [2:0]         game_state = 3'd0;
  logic [NP-1:0][3:0] pot_cell = '0;
  logic [NP-1:0][3:0] pot_time;
  logic               fire_alarm;

  int tests = 0;
  int fails = 0;

  pot_cook_scheduler_if upd();

  pot_cook_scheduler #(
    .NUM_POTS(4), .COOK_TIME(10), .BURN_TIME(5), .FRAMES_PER_SEC(60)
  ) dut (
    .vsync      (vsync),
    .reset      (reset),
    .game_state (game_state),
    .pot_cell   (pot_cell),
    .upd        (upd),
    .pot_time   (pot_time),
    .fire_alarm (fire_alarm)
  );

  // Falling edge is the active edge; the bench samples and drives on rising.
  always #5 vsync = ~vsync;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (cnt < limit && !seen) begin
      @(posedge vsync);
      cnt++;
      if (upd.upd_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_time(input int pot, input logic [3:0] val, input int limit,
                           output logic seen);
    int cnt;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < limit && !seen) begin
      @(posedge vsync);
      cnt++;
      if (pot_time[pot] === val) seen = 1'b1;
    end
  endtask

  initial begin
    int   cnt;
    logic seen;
    logic v_any;
    logic stable;

    upd.upd_ready = 1'b0;
    repeat (3) @(posedge vsync);
    check("rst_valid", 32'(upd.upd_valid), 32'd0);
    check("rst_idx",   32'(upd.upd_idx),   32'd0);
    check("rst_code",  32'(upd.upd_code),  32'd0);
    check("rst_time",  32'(pot_time),      32'd0);
    check("rst_alarm", 32'(fire_alarm),    32'd0);

    // Cook path on pot 1, prescaler starting from 0.
    reset         = 1'b0;
    game_state    = 3'd2;
    pot_cell[1]   = 4'd6;
    upd.upd_ready = 1'b1;
    @(posedge vsync);
    check("cook_start_time", 32'(pot_time[1]), 32'd10);
    wait_valid(700, cnt, seen);
    check("cook_seen",    32'(seen),         32'd1);
    check("cook_latency", 32'(cnt),          32'd600);
    check("cook_idx",     32'(upd.upd_idx),  32'd1);
    check("cook_code",    32'(upd.upd_code), 32'd7);
    @(posedge vsync);
    check("cook_pulse",     32'(upd.upd_valid), 32'd0);
    check("cook_burn_time", 32'(pot_time[1]),   32'(EXP_BURN));
    pot_cell[1] = 4'd0;
    @(posedge vsync);
    check("cook_removed", 32'(pot_time[1]), 32'd0);

    // Pause freezes timer and prescaler.
    pot_cell[0] = 4'd6;
    wait_time(0, 4'd4, 500, seen);
    check("pause_reach", 32'(seen), 32'd1);
    game_state = 3'd3;
    v_any = 1'b0;
    repeat (500) begin
      @(posedge vsync);
      if (upd.upd_valid !== 1'b0) v_any = 1'b1;
    end
    check("pause_time",  32'(pot_time[0]), 32'd4);
    check("pause_noreq", 32'(v_any),       32'd0);
    game_state = 3'd2;
    wait_valid(400, cnt, seen);
    check("resume_seen",    32'(seen),        32'd1);
    check("resume_latency", 32'(cnt),         32'd241);
    check("resume_idx",     32'(upd.upd_idx), 32'd0);
    @(posedge vsync);
    pot_cell[0] = 4'd0;
    @(posedge vsync);

    // Fresh start for arbitration so the pointer is 0.
    reset = 1'b1;
    @(posedge vsync);
    check("mid_rst_valid", 32'(upd.upd_valid), 32'd0);
    reset         = 1'b0;
    pot_cell[0]   = 4'd6;
    pot_cell[2]   = 4'd6;
    pot_cell[3]   = 4'd6;
    upd.upd_ready = 1'b0;
    wait_valid(700, cnt, seen);
    check("arb_seen",    32'(seen),         32'd1);
    check("arb_latency", 32'(cnt),          32'd601);
    check("arb_idx0",    32'(upd.upd_idx),  32'd0);
    check("arb_code0",   32'(upd.upd_code), 32'd7);
    stable = 1'b1;
    repeat (10) begin
      @(posedge vsync);
      if (upd.upd_valid !== 1'b1 || upd.upd_idx !== 2'd0 || upd.upd_code !== 4'd7)
        stable = 1'b0;
    end
    check("arb_stall_stable", 32'(stable), 32'd1);
    upd.upd_ready = 1'b1;
    @(posedge vsync);
    check("arb_valid2",  32'(upd.upd_valid), 32'd1);
    check("arb_idx2",    32'(upd.upd_idx),   32'd2);
    check("arb_p0_time", 32'(pot_time[0]),   32'(EXP_BURN));
    @(posedge vsync);
    check("arb_valid3", 32'(upd.upd_valid), 32'd1);
    check("arb_idx3",   32'(upd.upd_idx),   32'd3);
    @(posedge vsync);
    check("arb_done", 32'(upd.upd_valid), 32'd0);
    pot_cell = '0;
    @(posedge vsync);

    // Removal while cooking cancels everything.
    pot_cell[3] = 4'd6;
    wait_time(3, 4'd3, 600, seen);
    check("rm_reach", 32'(seen), 32'd1);
    pot_cell[3] = 4'd0;
    @(posedge vsync);
    check("rm_time", 32'(pot_time[3]), 32'd0);
    v_any = 1'b0;
    repeat (700) begin
      @(posedge vsync);
      if (upd.upd_valid !== 1'b0) v_any = 1'b1;
    end
    check("rm_noreq", 32'(v_any), 32'd0);

    // Burn phase (or its absence).
    pot_cell[1] = 4'd6;
    wait_valid(700, cnt, seen);
    check("burn_cook_seen", 32'(seen),         32'd1);
    check("burn_cook_code", 32'(upd.upd_code), 32'd7);
    pot_cell[1] = 4'd7;
    @(posedge vsync);
    check("burn_cooked_time", 32'(pot_time[1]), 32'(EXP_BURN));
`ifdef POT_BURN_EN
    wait_valid(400, cnt, seen);
    check("burn_seen", 32'(seen),         32'd1);
    check("burn_code", 32'(upd.upd_code), 32'd8);
    check("burn_idx",  32'(upd.upd_idx),  32'd1);
    pot_cell[1] = 4'd8;
    @(posedge vsync);
    check("alarm_on", 32'(fire_alarm), 32'd1);
    pot_cell[1] = 4'd10;
    @(posedge vsync);
    check("alarm_off", 32'(fire_alarm), 32'd0);
`else
    v_any = 1'b0;
    repeat (400) begin
      @(posedge vsync);
      if (upd.upd_valid !== 1'b0) v_any = 1'b1;
    end
    check("noburn_noreq", 32'(v_any),       32'd0);
    check("noburn_time",  32'(pot_time[1]), 32'd0);
    check("noburn_alarm", 32'(fire_alarm),  32'd0);
`endif
    pot_cell[1] = 4'd0;
    @(posedge vsync);

    // Asynchronous reset while a request is stalled.
    pot_cell[2]   = 4'd6;
    upd.upd_ready = 1'b0;
    wait_valid(700, cnt, seen);
    check("ar_seen", 32'(seen), 32'd1);
    pot_cell[0] = 4'd6;
    @(posedge vsync);
    check("ar_cooking", 32'(pot_time[0]),   32'd10);
    check("ar_pre",     32'(upd.upd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 32'(upd.upd_valid), 32'd0);
    check("ar_time",  32'(pot_time),      32'd0);
    check("ar_alarm", 32'(fire_alarm),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pot_cook_scheduler.md
Name: pot_cook_scheduler

Overview:
- Sequences cooking for the NUM_POTS stove pots: raw -> cooked -> burning -> fire.
- Owns the per-pot countdown timers and exposes remaining seconds for the time display.
- Arbitrates pot-state changes onto the single object-grid update port of the action block, using round-robin and a valid/ready handshake.
- Sits beside action: reads the pot cells of object_grid and returns grid writes.

Parameters:
- NUM_POTS, 4: number of tracked pot cells; index i maps to grid row 0, column 8+i.
- COOK_TIME, 10: seconds from RAW detected until a COOKED write is requested (1..15).
- BURN_TIME, 5: seconds from COOKED accepted until a FIRE write is requested (1..15).
- FRAMES_PER_SEC, 60: vsync frames per one-second tick.

Ports:
- vsync, input, 1: clock; all state updates on the falling edge.
- reset, input, 1: asynchronous, active-high.
- game_state, input, 3: timers advance only when the value is 2 (PLAY).
- pot_cell, input, NUM_POTS x 4: current grid codes of the pot cells.
- upd_valid, output, 1: grid write request.
- upd_idx, output, 2: pot index of the request.
- upd_code, output, 4: grid code to write, 7 (G_POT_COOKED) or 8 (G_POT_FIRE).
- upd_ready, input, 1: consumer accepts the request this edge.
- pot_time, output, NUM_POTS x 4: seconds remaining in the current phase; 0 when idle.
- fire_alarm, output, 1: high while any pot is ON_FIRE.

Behaviour:
- Reset values: all pots IDLE, pot_time=0, upd_valid=0, upd_idx=0, upd_code=0, fire_alarm=0, prescaler=0, round-robin pointer=0. Reset asserted mid-request drops upd_valid immediately; there is no completion of in-flight work.
- Prescaler: counts 0..FRAMES_PER_SEC-1 only while game_state==2 and holds otherwise. tick=1 on the edge where it wraps. PAUSE freezes every timer and the prescaler value.
- Per-pot FSM:
  - IDLE: pot_cell==6 (G_POT_RAW) -> COOKING, pot_time<=COOK_TIME.
  - COOKING: pot_cell!=6 -> IDLE, pot_time<=0 (pot picked up). Otherwise, on tick: pot_time>1 decrements; pot_time==1 -> pot_time<=0, go to COOK_PEND.
  - COOK_PEND: waiting for grant with code 7. On acceptance -> COOKED, pot_time<=BURN_TIME. If the pot is removed before grant -> IDLE, request withdrawn (allowed only while not presented).
  - COOKED: exit to IDLE only when pot_cell is neither 7 nor 6; the 6 case tolerates the one-frame write lag. Countdown on tick exactly as in COOKING; reaching 0 -> FIRE_PEND.
  - FIRE_PEND: as COOK_PEND, with code 8; acceptance -> ON_FIRE, pot_time=0.
  - ON_FIRE: exit to IDLE when pot_cell is neither 8 nor 7 (extinguished or removed).
- Arbitration:
  - At most one request is presented. When upd_valid==0, or on the same edge it is accepted, select the first pending pot at or after (pointer) modulo NUM_POTS.
  - upd_valid rises on the edge after a pot enters a PEND state.
  - upd_idx and upd_code are held stable while upd_valid && !upd_ready; a presented request is never withdrawn, even if its pot is removed.
  - The consumer applies a write only if the cell still holds the predecessor code (6 for code 7, 7 for code 8); otherwise it discards the write.
  - On acceptance, pointer <= upd_idx+1.
  - Back-to-back acceptance of different pots is allowed, one per edge.
- Simultaneous events: tick and removal on the same edge means removal wins (IDLE). All pots hitting zero on the same tick are serialized in round-robin order.
- fire_alarm is registered: the OR of ON_FIRE states.

Optional Feature:
- POT_BURN_EN.
- Defined: full behaviour as described.
- Undefined:
  - COOKED holds indefinitely with pot_time=0.
  - FIRE_PEND and ON_FIRE are not built.
  - upd_code is only ever 7.
  - fire_alarm is tied to 0.

Test Plan:
- Cook path: game_state=2, pot_cell[1]=6, upd_ready=1. After 10 ticks (600 frames ±60 prescaler phase), expect a single upd_valid pulse with upd_idx=1, upd_code=7; pot_time[1] then reads 5.
- Pause: cook pot 0 to pot_time=4, set game_state=3 for 500 frames. Expect pot_time constant at 4 and no request; resume and expect the request after 4 more ticks.
- Arbitration: pots 0,2,3 set RAW on the same frame, upd_ready=0 for 10 frames, then 1. Expect grants to pots 0, 2, 3 in that order on consecutive edges, with fields stable while stalled.
- Removal: pot 3 RAW with pot_time=3, then pot_cell[3]=0. Expect next state IDLE, pot_time[3]=0, no request ever issued.
- Burn (POT_BURN_EN): leave a cooked pot for 5 ticks. Expect upd_code=8, then fire_alarm=1; set pot_cell=10 and expect fire_alarm=0 on the next edge.
- Async reset during upd_valid=1 with upd_ready=0: expect upd_valid=0 and all pot_time=0 without waiting for a vsync edge.
